encoder_16to4_drain: RTL and testbench

// - Sequential 16-to-4 encoder; inverse of the 4-to-16 one-hot decoder.
// - Accepts a 16-bit request vector (one-hot or multi-hot) and emits the binary index of every set bit, one index per handshake.
// - Serves as the encode end of the one-hot select path, e.g. interrupt/request drain ahead of a 4-bit bus.

---
 rtl/encoder_16to4_drain_pkg.sv | 12 +
 rtl/encoder_16to4_drain_pri_enc16.sv | 29 ++
 rtl/encoder_16to4_drain.sv | 99 +++++++++
 tb/tb_encoder_16to4_drain.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_16to4_drain_pkg.sv
// Shared types and sizes for the 16-to-4 draining encoder.
package encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int ENC_WIDTH = 16;
  localparam int ENC_IDX_W = 4;

endpackage

// File: rtl/encoder_16to4_drain_pri_enc16.sv
// Combinational priority encoder with a selectable search direction and an
// exactly-one-bit-set flag.
module pri_enc16 #(
  parameter int WIDTH     = 16,
  parameter int IDX_W     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_onehot
);

  // The last assignment in the scan wins, so scan away from the preferred end.
  always_comb begin
    o_idx = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i_vec[i]) o_idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i_vec[i]) o_idx = IDX_W'(i);
      end
    end
  end

  assign o_onehot = (i_vec != '0) && ((i_vec & (i_vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/encoder_16to4_drain.sv
// Sequential 16-to-4 encoder: captures a request vector and drains the index
// of every set bit, one per out_valid/out_ready handshake.
module encoder_16to4_drain
  import encoder_pkg::*;
#(
  parameter int WIDTH     = ENC_WIDTH,
  parameter int IDX_W     = ENC_IDX_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_err
);

  if (IDX_W != $clog2(WIDTH) || WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_param_check
    $error("encoder_16to4_drain: WIDTH must be a power of 2 >= 2 and IDX_W == $clog2(WIDTH)");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_pending_nxt;
  logic [WIDTH-1:0] w_clr_mask;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_out_last;
  logic             r_zero_err;
  logic             w_zero_nxt;
  logic [IDX_W-1:0] w_enc_idx;
  logic             w_enc_onehot;

  assign w_clr_mask = WIDTH'(1) << r_out_idx;

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_zero_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (in_vec == '0) begin
            w_zero_nxt = 1'b1;
          end else begin
            w_pending_nxt = in_vec;
            w_state_nxt   = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_pending_nxt = r_pending & ~w_clr_mask;
          if (r_out_last) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Encode the next pending value so out_idx/out_last are registered and
  // already correct in the cycle the beat is presented.
  pri_enc16 #(
    .WIDTH    (WIDTH),
    .IDX_W    (IDX_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_pri_enc (
    .i_vec   (w_pending_nxt),
    .o_idx   (w_enc_idx),
    .o_onehot(w_enc_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_out_idx  <= '0;
      r_out_last <= 1'b0;
      r_zero_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_out_idx  <= w_enc_idx;
      r_out_last <= w_enc_onehot;
      r_zero_err <= w_zero_nxt;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == EMIT);
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign zero_err  = r_zero_err;

endmodule

// File: tb/tb_encoder_16to4_drain.sv
// Bench for encoder_16to4_drain: LSB-first and MSB-first instances share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_encoder_16to4_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_vec;
  logic        out_ready;

  logic       in_ready_l, out_valid_l, out_last_l, zero_err_l;
  logic [3:0] out_idx_l;
  logic       in_ready_m, out_valid_m, out_last_m, zero_err_m;
  logic [3:0] out_idx_m;

  always #5 clk = ~clk;

  encoder_16to4_drain #(.WIDTH(16), .IDX_W(4), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in_vec(in_vec),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_idx(out_idx_l),
    .out_last(out_last_l), .zero_err(zero_err_l)
  );

  encoder_16to4_drain #(.WIDTH(16), .IDX_W(4), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .in_vec(in_vec),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_idx(out_idx_m),
    .out_last(out_last_m), .zero_err(zero_err_m)
  );

  // Reference model: the set-bit indices still to be emitted, in emission order.
  bit m_busy;
  bit m_zero;
  int m_ql[$];
  int m_qm[$];

  int n_checks = 0;
  int n_errors = 0;
  int beats_l[$];
  int beats_m[$];

  typedef struct {
    logic [15:0] vec;
    int          n_beats;
    int          lo;
    int          hi;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_busy = 1'b0;
      m_zero = 1'b0;
      m_ql.delete();
      m_qm.delete();
    end else begin
      m_zero = 1'b0;
      if (!m_busy) begin
        if (in_valid) begin
          if (in_vec == 16'h0) begin
            m_zero = 1'b1;
          end else begin
            for (int i = 0; i < 16; i++) begin
              if (in_vec[i]) begin
                m_ql.push_back(i);
                m_qm.push_front(i);
              end
            end
            m_busy = 1'b1;
          end
        end
      end else if (out_ready) begin
        void'(m_ql.pop_front());
        void'(m_qm.pop_front());
        if (m_ql.size() == 0) m_busy = 1'b0;
      end
    end
  endtask

  task automatic step();
    if (out_valid_l && out_ready) beats_l.push_back(int'(out_idx_l));
    if (out_valid_m && out_ready) beats_m.push_back(int'(out_idx_m));
    @(posedge clk);
    model_edge();
    #1;
    chk("in_ready_lsb", in_ready_l, !m_busy);
    chk("out_valid_lsb", out_valid_l, m_busy);
    chk("zero_err_lsb", zero_err_l, m_zero);
    chk("in_ready_msb", in_ready_m, !m_busy);
    chk("out_valid_msb", out_valid_m, m_busy);
    chk("zero_err_msb", zero_err_m, m_zero);
    if (m_busy) begin
      chk("out_idx_lsb", out_idx_l, m_ql[0]);
      chk("out_last_lsb", out_last_l, m_ql.size() == 1);
      chk("out_idx_msb", out_idx_m, m_qm[0]);
      chk("out_last_msb", out_last_m, m_qm.size() == 1);
    end
  endtask

  task automatic apply_vec(input logic [15:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    step();
    in_valid = 1'b0;
    in_vec   = 16'($urandom);
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && m_busy; c++) step();
    if (m_busy) chk({nm, "_drain_timeout"}, 1, 0);
    step();
    chk({nm, "_in_ready_after"}, in_ready_l, 1);
  endtask

  initial begin
    tbl.push_back('{16'h0008, 1, 3, 3});
    tbl.push_back('{16'h8001, 2, 0, 15});
    tbl.push_back('{16'h0001, 1, 0, 0});
    tbl.push_back('{16'h8000, 1, 15, 15});
    tbl.push_back('{16'h0120, 2, 5, 8});
    tbl.push_back('{16'hFFFF, 16, 0, 15});
    tbl.push_back('{16'h0A50, 4, 4, 11});

    rst = 1'b1; in_valid = 1'b0; in_vec = 16'h0; out_ready = 1'b0;
    step();
    step();
    chk("reset_out_idx", out_idx_l, 0);
    chk("reset_out_last", out_last_l, 0);
    chk("reset_in_ready", in_ready_l, 1);
    rst = 1'b0;
    step();
    chk("after_reset_in_ready", in_ready_l, 1);

    // Table-driven single vectors
    foreach (tbl[t]) begin
      beats_l.delete();
      beats_m.delete();
      out_ready = 1'b1;
      apply_vec(tbl[t].vec);
      drain("tbl");
      chk("tbl_nbeats_lsb", beats_l.size(), tbl[t].n_beats);
      chk("tbl_nbeats_msb", beats_m.size(), tbl[t].n_beats);
      chk("tbl_first_lsb", beats_l.size() > 0 ? beats_l[0] : -1, tbl[t].lo);
      chk("tbl_final_lsb", beats_l.size() > 0 ? beats_l[$] : -1, tbl[t].hi);
      chk("tbl_first_msb", beats_m.size() > 0 ? beats_m[0] : -1, tbl[t].hi);
      chk("tbl_final_msb", beats_m.size() > 0 ? beats_m[$] : -1, tbl[t].lo);
    end

    // Back-pressure with in_vec churning during EMIT
    out_ready = 1'b0;
    apply_vec(16'h0120);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_idx", out_idx_l, 5);
      chk("bp_hold_last", out_last_l, 0);
      chk("bp_hold_valid", out_valid_l, 1);
      in_vec = 16'($urandom);
      if (c < 2) step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_second_idx", out_idx_l, 8);
    chk("bp_second_last", out_last_l, 1);
    step();
    chk("bp_done_in_ready", in_ready_l, 1);

    // Zero vector
    in_valid = 1'b1; in_vec = 16'h0;
    step();
    chk("zero_pulse", zero_err_l, 1);
    chk("zero_no_valid", out_valid_l, 0);
    in_valid = 1'b0;
    step();
    chk("zero_pulse_end", zero_err_l, 0);

    // Reset in the middle of a full-vector drain
    out_ready = 1'b1;
    apply_vec(16'hFFFF);
    for (int c = 0; c < 4; c++) step();
    chk("mid_idx_before_rst", out_idx_l, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid_l, 0);
    chk("mid_rst_in_ready", in_ready_l, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_no_beats", out_valid_l, 0);
    end

    // Loopback through a behavioural 4-to-16 decoder
    for (int a = 0; a < 16; a++) begin
      logic [15:0] q;
      q = 16'(1) << a;
      out_ready = 1'b1;
      apply_vec(q);
      chk("loop_idx", out_idx_l, a);
      chk("loop_last", out_last_l, 1);
      drain("loop");
    end

    // Randomized traffic against the model
    for (int it = 0; it < 1500; it++) begin
      in_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: in_vec = 16'h0;
        1: in_vec = 16'(1) << $urandom_range(0, 15);
        2: in_vec = 16'($urandom);
        default: in_vec = 16'($urandom) & 16'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
